// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and the external DM.
// The stage drives address, lane data and byte enables; DM returns read data combinationally.
interface mem_stage_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic [31:0] m_inst_addr;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output m_data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: E/M and M/W pipeline registers, DM store lane steering,
// load extension, and the M/W-level forwarding values.
module mem_stage #(
  parameter logic [31:0] PC_LINK_OFS = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_M,
  input  logic [31:0] result_E_i,
  input  logic [31:0] md_E_i,
  input  logic [31:0] RD2_E_i,
  input  logic [4:0]  A2_E_i,
  input  logic [4:0]  A3_E_i,
  input  logic        regWrite_E_i,
  input  logic [31:0] PCn_E_i,
  input  logic [31:0] OP_E_i,
  mem_stage_if.master dm,
  output logic [31:0] M_result,
  output logic [4:0]  A3_M_o,
  output logic        regWrite_M_o,
  output logic        isLoad_M_o,
  output logic [31:0] W_forward,
  output logic [4:0]  A3_W_o,
  output logic        regWrite_W_o,
  output logic [31:0] PC_W_o
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_SPEC  = 6'b000000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // Only the opcode and funct fields are decoded, so only those are kept in E/M.
  logic        unused_op_bits;
  assign unused_op_bits = ^OP_E_i[25:6];

  logic [31:0] result_m, md_m, rd2_m, pc_m;
  logic [4:0]  a2_m, a3_m;
  logic        regwrite_m;
  logic [5:0]  opc_m, fn_m;

  always_ff @(posedge clk) begin
    if (reset || flush_M) begin
      result_m   <= '0;
      md_m       <= '0;
      rd2_m      <= '0;
      pc_m       <= '0;
      a2_m       <= '0;
      a3_m       <= '0;
      regwrite_m <= 1'b0;
      opc_m      <= '0;
      fn_m       <= '0;
    end else begin
      result_m   <= result_E_i;
      md_m       <= md_E_i;
      rd2_m      <= RD2_E_i;
      pc_m       <= PCn_E_i;
      a2_m       <= A2_E_i;
      a3_m       <= A3_E_i;
      regwrite_m <= regWrite_E_i;
      opc_m      <= OP_E_i[31:26];
      fn_m       <= OP_E_i[5:0];
    end
  end

  logic is_lw, is_lb, is_lbu, is_lh, is_lhu, is_sw, is_sb, is_sh;
  logic is_link, is_mf;

  always_comb begin
    is_lw   = (opc_m == OP_LW);
    is_lb   = (opc_m == OP_LB);
    is_lbu  = (opc_m == OP_LBU);
    is_lh   = (opc_m == OP_LH);
    is_lhu  = (opc_m == OP_LHU);
    is_sw   = (opc_m == OP_SW);
    is_sb   = (opc_m == OP_SB);
    is_sh   = (opc_m == OP_SH);
    is_link = (opc_m == OP_JAL) || (opc_m == OP_SPEC && fn_m == FN_JALR);
    is_mf   = (opc_m == OP_SPEC) && (fn_m == FN_MFHI || fn_m == FN_MFLO);
  end

  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [1:0]  addr_lo;

  assign addr_lo = result_m[1:0];

  // W holds the pre-edge value here, so a load or ALU write just ahead is caught.
  assign store_data = (regWrite_W_o && (A3_W_o == a2_m) && (a2_m != 5'd0)) ? W_forward : rd2_m;

  always_comb begin
    dm.m_data_byteen = 4'b0000;
    dm.m_data_wdata  = store_data;
    if (is_sw) begin
      dm.m_data_byteen = 4'b1111;
    end else if (is_sh) begin
      dm.m_data_byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
      dm.m_data_wdata  = {2{store_data[15:0]}};
    end else if (is_sb) begin
      dm.m_data_byteen = 4'b0001 << addr_lo;
      dm.m_data_wdata  = {4{store_data[7:0]}};
    end
  end

  assign dm.m_data_addr = {result_m[31:2], 2'b00};
  assign dm.m_inst_addr = pc_m;

  always_comb begin
    sel_byte  = 8'h00;
    case (addr_lo)
      2'd0: sel_byte = dm.m_data_rdata[7:0];
      2'd1: sel_byte = dm.m_data_rdata[15:8];
      2'd2: sel_byte = dm.m_data_rdata[23:16];
      2'd3: sel_byte = dm.m_data_rdata[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half  = addr_lo[1] ? dm.m_data_rdata[31:16] : dm.m_data_rdata[15:0];
    load_data = dm.m_data_rdata;
    if (is_lb)       load_data = {{24{sel_byte[7]}}, sel_byte};
    else if (is_lbu) load_data = {24'h0, sel_byte};
    else if (is_lh)  load_data = {{16{sel_half[15]}}, sel_half};
    else if (is_lhu) load_data = {16'h0, sel_half};
  end

  always_comb begin
    M_result = result_m;
    if (is_link)    M_result = pc_m + PC_LINK_OFS;
    else if (is_mf) M_result = md_m;
  end

  assign A3_M_o       = a3_m;
  assign regWrite_M_o = regwrite_m;
  assign isLoad_M_o   = is_lw | is_lb | is_lbu | is_lh | is_lhu;

  always_ff @(posedge clk) begin
    if (reset) begin
      W_forward    <= '0;
      A3_W_o       <= '0;
      regWrite_W_o <= 1'b0;
      PC_W_o       <= '0;
    end else begin
      W_forward    <= isLoad_M_o ? load_data : M_result;
      A3_W_o       <= a3_m;
      regWrite_W_o <= regwrite_m;
      PC_W_o       <= pc_m;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_JAL = 6'b000011;

  logic        clk = 1'b0;
  logic        reset, flush_M;
  logic [31:0] result_E_i, md_E_i, RD2_E_i, PCn_E_i, OP_E_i;
  logic [4:0]  A2_E_i, A3_E_i;
  logic        regWrite_E_i;
  logic [31:0] M_result, W_forward, PC_W_o;
  logic [4:0]  A3_M_o, A3_W_o;
  logic        regWrite_M_o, isLoad_M_o, regWrite_W_o;
  int checks = 0;
  int errors = 0;

  mem_stage_if dm ();

  mem_stage #(.PC_LINK_OFS(32'd8)) dut (
    .clk(clk), .reset(reset), .flush_M(flush_M),
    .result_E_i(result_E_i), .md_E_i(md_E_i), .RD2_E_i(RD2_E_i),
    .A2_E_i(A2_E_i), .A3_E_i(A3_E_i), .regWrite_E_i(regWrite_E_i),
    .PCn_E_i(PCn_E_i), .OP_E_i(OP_E_i), .dm(dm.master),
    .M_result(M_result), .A3_M_o(A3_M_o), .regWrite_M_o(regWrite_M_o),
    .isLoad_M_o(isLoad_M_o), .W_forward(W_forward), .A3_W_o(A3_W_o),
    .regWrite_W_o(regWrite_W_o), .PC_W_o(PC_W_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] res, input logic [31:0] md, input logic [31:0] rd2,
                       input logic [4:0] a2, input logic [4:0] a3, input logic rw,
                       input logic [31:0] pc);
    OP_E_i = {op, 20'h0, fn};
    result_E_i = res; md_E_i = md; RD2_E_i = rd2;
    A2_E_i = a2; A3_E_i = a3; regWrite_E_i = rw; PCn_E_i = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_M = 1'b0; dm.m_data_rdata = 32'h0;
    drive(OP_SW, 6'h0, 32'h44, 32'h1, 32'hFFFF_FFFF, 5'd3, 5'd3, 1'b1, 32'h3000);
    tick(); tick();
    checks++; if (dm.m_data_byteen !== 4'b0000) begin errors++; $display("FAIL reset_byteen got %b exp 0000", dm.m_data_byteen); end
    checks++; if (dm.m_data_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", dm.m_data_addr); end
    checks++; if (M_result !== 32'h0) begin errors++; $display("FAIL reset_M_result got %h exp 0", M_result); end
    checks++; if (regWrite_M_o !== 1'b0 || A3_M_o !== 5'd0) begin errors++; $display("FAIL reset_M_ctrl got %b/%0d exp 0/0", regWrite_M_o, A3_M_o); end
    checks++; if (W_forward !== 32'h0 || regWrite_W_o !== 1'b0 || PC_W_o !== 32'h0) begin errors++; $display("FAIL reset_W got %h/%b/%h exp 0", W_forward, regWrite_W_o, PC_W_o); end
    reset = 1'b0;
    drive(6'h0, 6'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    checks++; if (dm.m_inst_addr !== 32'h0 || dm.m_data_byteen !== 4'b0000) begin errors++; $display("FAIL post_reset got %h/%b exp 0/0000", dm.m_inst_addr, dm.m_data_byteen); end
  endtask

  task automatic test_store_forward();
    drive(OP_LW, 6'h0, 32'h20, 32'h0, 32'h0, 5'd0, 5'd8, 1'b1, 32'h3010);
    tick();
    dm.m_data_rdata = 32'h1234_5678;
    checks++; if (isLoad_M_o !== 1'b1) begin errors++; $display("FAIL lw_isLoad got %b exp 1", isLoad_M_o); end
    drive(OP_SW, 6'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 5'd8, 5'd0, 1'b0, 32'h3014);
    tick();
    checks++; if (W_forward !== 32'h1234_5678 || A3_W_o !== 5'd8) begin errors++; $display("FAIL lw_W got %h/%0d exp 12345678/8", W_forward, A3_W_o); end
    checks++; if (dm.m_data_byteen !== 4'b1111 || dm.m_data_addr !== 32'h10) begin errors++; $display("FAIL sw_fwd_be got %b/%h exp 1111/10", dm.m_data_byteen, dm.m_data_addr); end
    checks++; if (dm.m_data_wdata !== 32'h1234_5678) begin errors++; $display("FAIL sw_fwd_data got %h exp 12345678", dm.m_data_wdata); end
    checks++; if (isLoad_M_o !== 1'b0) begin errors++; $display("FAIL sw_isLoad got %b exp 0", isLoad_M_o); end
    drive(OP_SW, 6'h0, 32'h17, 32'h0, 32'hCAFE_F00D, 5'd9, 5'd0, 1'b0, 32'h3018);
    tick();
    checks++; if (dm.m_data_wdata !== 32'hCAFE_F00D || dm.m_data_addr !== 32'h14) begin errors++; $display("FAIL sw_nofwd got %h/%h exp cafef00d/14", dm.m_data_wdata, dm.m_data_addr); end
  endtask

  task automatic test_store_lanes();
    drive(OP_SB, 6'h0, 32'h3, 32'h0, 32'h0000_00AB, 5'd9, 5'd0, 1'b0, 32'h3020);
    tick();
    checks++; if (dm.m_data_byteen !== 4'b1000 || dm.m_data_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_addr3 got %b/%h exp 1000/abababab", dm.m_data_byteen, dm.m_data_wdata); end
    drive(OP_SB, 6'h0, 32'h1, 32'h0, 32'h0000_00CD, 5'd9, 5'd0, 1'b0, 32'h3024);
    tick();
    checks++; if (dm.m_data_byteen !== 4'b0010 || dm.m_data_wdata !== 32'hCDCD_CDCD) begin errors++; $display("FAIL sb_addr1 got %b/%h exp 0010/cdcdcdcd", dm.m_data_byteen, dm.m_data_wdata); end
    drive(OP_SH, 6'h0, 32'h2, 32'h0, 32'h5555_1234, 5'd9, 5'd0, 1'b0, 32'h3028);
    tick();
    checks++; if (dm.m_data_byteen !== 4'b1100 || dm.m_data_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_addr2 got %b/%h exp 1100/12341234", dm.m_data_byteen, dm.m_data_wdata); end
    drive(OP_SH, 6'h0, 32'h40, 32'h0, 32'h0000_BEEF, 5'd9, 5'd0, 1'b0, 32'h302C);
    tick();
    checks++; if (dm.m_data_byteen !== 4'b0011 || dm.m_data_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_addr0 got %b/%h exp 0011/beefbeef", dm.m_data_byteen, dm.m_data_wdata); end
  endtask

  task automatic test_loads();
    logic [5:0]  ops [6] = '{OP_LB, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    logic [31:0] adr [6] = '{32'h1, 32'h3, 32'h3, 32'h2, 32'h2, 32'h0};
    logic [31:0] exp [6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080,
                             32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
    dm.m_data_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 6'h0, adr[i], 32'h0, 32'h0, 5'd0, 5'd10, 1'b1, 32'h3100);
      tick();
      drive(6'h0, 6'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
      tick();
      checks++; if (W_forward !== exp[i] || regWrite_W_o !== 1'b1) begin errors++; $display("FAIL load_%0d got %h/%b exp %h/1", i, W_forward, regWrite_W_o, exp[i]); end
    end
  endtask

  task automatic test_link_mf();
    drive(OP_JAL, 6'h0, 32'h1234, 32'h77, 32'h0, 5'd0, 5'd31, 1'b1, 32'h0000_3000);
    tick();
    checks++; if (M_result !== 32'h0000_3008 || A3_M_o !== 5'd31 || regWrite_M_o !== 1'b1) begin errors++; $display("FAIL jal_M got %h/%0d exp 3008/31", M_result, A3_M_o); end
    drive(6'h0, 6'b010010, 32'h99, 32'h55, 32'h0, 5'd0, 5'd4, 1'b1, 32'h0000_3004);
    tick();
    checks++; if (M_result !== 32'h55) begin errors++; $display("FAIL mflo_M got %h exp 55", M_result); end
    checks++; if (W_forward !== 32'h0000_3008 || A3_W_o !== 5'd31 || PC_W_o !== 32'h3000) begin errors++; $display("FAIL jal_W got %h/%0d/%h exp 3008/31/3000", W_forward, A3_W_o, PC_W_o); end
    drive(6'h0, 6'b001001, 32'h99, 32'h66, 32'h0, 5'd0, 5'd5, 1'b1, 32'h0000_0100);
    tick();
    checks++; if (M_result !== 32'h0000_0108) begin errors++; $display("FAIL jalr_M got %h exp 108", M_result); end
    drive(6'h0, 6'b010000, 32'h99, 32'hABCD, 32'h0, 5'd0, 5'd6, 1'b1, 32'h0000_0104);
    tick();
    checks++; if (M_result !== 32'hABCD) begin errors++; $display("FAIL mfhi_M got %h exp abcd", M_result); end
    drive(6'b001001, 6'h0, 32'h0000_4321, 32'h66, 32'h0, 5'd0, 5'd7, 1'b1, 32'h0000_0108);
    tick();
    checks++; if (M_result !== 32'h4321 || isLoad_M_o !== 1'b0) begin errors++; $display("FAIL alu_M got %h/%b exp 4321/0", M_result, isLoad_M_o); end
  endtask

  task automatic test_flush();
    flush_M = 1'b1;
    drive(OP_SW, 6'h0, 32'h30, 32'h0, 32'h1111_2222, 5'd9, 5'd12, 1'b1, 32'h3200);
    tick();
    flush_M = 1'b0;
    checks++; if (dm.m_data_byteen !== 4'b0000 || regWrite_M_o !== 1'b0 || M_result !== 32'h0) begin errors++; $display("FAIL flush got %b/%b/%h exp 0000/0/0", dm.m_data_byteen, regWrite_M_o, M_result); end
  endtask

  task automatic test_reset_midstream();
    drive(OP_SW, 6'h0, 32'h50, 32'h0, 32'h3333_4444, 5'd9, 5'd0, 1'b0, 32'h3300);
    tick();
    checks++; if (dm.m_data_byteen !== 4'b1111) begin errors++; $display("FAIL mid_sw_be got %b exp 1111", dm.m_data_byteen); end
    reset = 1'b1; flush_M = 1'b1;
    drive(OP_JAL, 6'h0, 32'h60, 32'h0, 32'h0, 5'd0, 5'd31, 1'b1, 32'h3304);
    tick();
    checks++; if (dm.m_data_byteen !== 4'b0000 || dm.m_data_addr !== 32'h0 || dm.m_inst_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_dm got %b/%h/%h exp 0", dm.m_data_byteen, dm.m_data_addr, dm.m_inst_addr); end
    checks++; if (W_forward !== 32'h0 || regWrite_W_o !== 1'b0 || PC_W_o !== 32'h0 || A3_W_o !== 5'd0) begin errors++; $display("FAIL mid_rst_W got %h/%b/%h exp 0", W_forward, regWrite_W_o, PC_W_o); end
    reset = 1'b0; flush_M = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_forward();
    test_store_lanes();
    test_loads();
    test_link_mf();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
